// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code-set-2 decoder: turns controller bytes into key events and held/pressed state for the game controls.
// Optional prefix timeout is enabled by defining PS2_KEY_TIMEOUT_EN.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       clear_keys,
    output logic [6:0] key_state,
    output logic [6:0] key_press,
    output logic       event_valid,
    output logic [7:0] event_code,
    output logic       event_extended,
    output logic       event_release
);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t     state, next_state;
    logic       emit, emit_ext, emit_rel;
    logic       timeout_hit;
    logic [6:0] key_mask, next_keys;
    logic       is_prefix;

    assign is_prefix = (received_data == 8'hE0) || (received_data == 8'hF0);

`ifdef PS2_KEY_TIMEOUT_EN
    logic [31:0] timeout_count;

    // A byte arriving on the expiry cycle wins, so expiry requires an idle input.
    assign timeout_hit = (state != IDLE) && !received_data_en &&
                         (timeout_count == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            timeout_count <= 32'd0;
        else if (received_data_en || timeout_hit || state == IDLE)
            timeout_count <= 32'd0;
        else
            timeout_count <= timeout_count + 32'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_rel   = 1'b0;
        if (received_data_en) begin
            case (state)
                IDLE: begin
                    if (received_data == 8'hE0)
                        next_state = EXT;
                    else if (received_data == 8'hF0)
                        next_state = BRK;
                    else
                        emit = 1'b1;
                end
                EXT: begin
                    if (received_data == 8'hF0)
                        next_state = EXT_BRK;
                    else if (received_data != 8'hE0) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        next_state = IDLE;
                    end
                end
                BRK: begin
                    if (!is_prefix) begin
                        emit       = 1'b1;
                        emit_rel   = 1'b1;
                        next_state = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (!is_prefix) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        emit_rel   = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end else if (timeout_hit) begin
            next_state = IDLE;
        end
    end

    // Keypad Enter (E0 5A) deliberately falls through to no key.
    always_comb begin
        key_mask = 7'b0000000;
        case ({emit_ext, received_data})
            9'h175:  key_mask = 7'b0000001;
            9'h172:  key_mask = 7'b0000010;
            9'h16B:  key_mask = 7'b0000100;
            9'h174:  key_mask = 7'b0001000;
            9'h01A:  key_mask = 7'b0010000;
            9'h022:  key_mask = 7'b0100000;
            9'h05A:  key_mask = 7'b1000000;
            default: key_mask = 7'b0000000;
        endcase
    end

    always_comb begin
        next_keys = key_state;
        if (emit) begin
            if (emit_rel)
                next_keys = key_state & ~key_mask;
            else
                next_keys = key_state | key_mask;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_state      <= 7'd0;
            key_press      <= 7'd0;
            event_valid    <= 1'b0;
            event_code     <= 8'h00;
            event_extended <= 1'b0;
            event_release  <= 1'b0;
        end else begin
            event_valid <= emit;
            if (emit) begin
                event_code     <= received_data;
                event_extended <= emit_ext;
                event_release  <= emit_rel;
            end
            if (clear_keys) begin
                key_state <= 7'd0;
                key_press <= 7'd0;
            end else begin
                key_state <= next_keys;
                key_press <= next_keys & ~key_state;
            end
        end
    end

endmodule
